ldl_cdc_arb_v1: RTL
===================

# LDL_cdc_arb_v1

Round-robin scheduler that shares one toggle-handshake CDC channel among N requesters in the transmit clock domain. It accepts one word per grant from valid/ready requesters and presents it as a held data word plus requester index and a state toggle bit. It keeps each word stable for a programmable number of cycles so the receive side can sample it safely. It sits directly in front of the CDC toggle/data flops and replaces their free-running pacing counter with demand-driven sequencing.

## Interface
- N, 4: number of requesters (min 2)
- DW, 8: data width per requester
- CW, 8: width of the hold count `num`
- IW, 2: requester index width; 2^IW >= N required
- clk  in  1  single clock (transmit domain)
- rst  in  1  synchronous, active-high reset
- en  in  1  grant enable; when low no new grant is issued, and a hold in progress completes
- num  in  CW  hold length in clk cycles; 0 is treated as 1; sampled at grant
- req_vld  in  N  per-requester word valid
- req_data  in  N*DW  requester i word at bits [i*DW +: DW]
- req_rdy  out  N  one-hot accept strobe, combinational
- cdc_st  out  1  state toggle bit to CDC synchronizer
- cdc_data  out  DW  held word to CDC data flops
- cdc_id  out  IW  index of requester owning cdc_data
- busy  out  1  high while in HOLD

## Operation
- States:
  - IDLE: may grant.
  - HOLD: output frozen; counting.
- Grant in IDLE when en=1 and any req_vld=1:
  - Winner is the first set req_vld at or after ptr, scanning upward mod N.
  - req_rdy[winner]=1 in that same cycle; all other req_rdy bits are 0.
  - req_rdy is always all-zero in HOLD, when en=0, or when no requester is valid.
- On a grant, at the next edge:
  - cdc_data <= winner's word
  - cdc_id <= winner
  - cdc_st <= ~cdc_st
  - num_q <= max(num,1)
  - cnt <= 0
  - ptr <= (winner+1) mod N
  - state <= HOLD
- HOLD:
  - cnt increments each cycle.
  - When cnt == num_q-1, state goes to IDLE at the next edge. HOLD therefore lasts exactly num_q cycles.
- Changing num during HOLD has no effect until the next grant.
- Deasserting en during HOLD does not shorten the hold.
- A requester that drops req_vld before being granted loses its turn. No request is latched internally.
- cdc_st, cdc_data and cdc_id change only on the grant edge. They are never modified in HOLD or in IDLE without a grant.
- The cnt compare uses CW bits with no wrap; cnt never exceeds num_q-1.

## Timing
- Reset values: state IDLE, cdc_st 0, cdc_data 0, cdc_id 0, ptr 0, cnt 0, num_q 1, busy 0, req_rdy 0.
- Reset mid-HOLD returns to IDLE at the reset edge and clears cdc_st to 0. Receive side must be reset together.
- Grant-to-output latency: 1 cycle. Outputs update on the edge after the cycle in which req_rdy is high.
- Minimum spacing between cdc_st toggles: max(num,1)+1 cycles (HOLD cycles plus one IDLE grant cycle).
- Under continuous demand with num=K, one word is issued every K+1 cycles.
- Fairness: with all N requesters continuously valid, grants rotate 0,1,…,N-1,0,… Each requester waits at most N-1 other grants.
- busy is registered, equals (state==HOLD), and rises on the same edge as the cdc_st toggle.
- num must satisfy num*clk_period > 3*rx_clk_period. The block does not check this.

## Test plan
- Reset then idle: rst=1 for 2 cycles, req_vld=0 → all outputs 0, req_rdy=0, busy=0, for 20 cycles.
- Single request, num=3: req_vld=4'b0100, data2=8'hA5 → req_rdy=4'b0100 for one cycle; next cycle cdc_data=A5, cdc_id=2, cdc_st=1, busy=1 for 3 cycles; no toggle for 4 cycles.
- Full-load rotation, num=2, all req_vld=1 → grant order 0,1,2,3,0; cdc_st toggles every 3 cycles; cdc_id follows the grant order.
- num=0 and num change mid-HOLD: num=0 gives spacing 2. num=5 granted, then num=1 written in HOLD cycle 2 → HOLD still lasts 5 cycles; next hold lasts 1 cycle.
- en gating: en=0 with requests pending → req_rdy=0, no toggle. en falling mid-HOLD → hold completes; no grant until en=1.
- Reset mid-HOLD with cdc_st=1 → next cycle state IDLE, cdc_st=0, ptr=0; the following grant goes to the lowest valid index.

Source files
------------

// File: rtl/ldl_cdc_arb_v1.sv
// rtl/ldl_cdc_arb_v1.sv - round-robin arbiter feeding a toggle-handshake CDC channel
module ldl_cdc_arb_v1 #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int CW = 8,
    parameter int IW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [CW-1:0]   num,
    input  logic [N-1:0]    req_vld,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    req_rdy,
    output logic            cdc_st,
    output logic [DW-1:0]   cdc_data,
    output logic [IW-1:0]   cdc_id,
    output logic            busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] num_q;
    logic [CW-1:0] num_eff;
    logic [IW:0]   scan;
    logic [IW-1:0] win_idx;
    logic          win_found;
    logic          grant;

    // Scan downward so the last hit is the first valid index at or after ptr.
    always_comb begin
        scan      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            scan = {1'b0, ptr} + (IW + 1)'(k);
            if (scan >= (IW + 1)'(N)) begin
                scan = scan - (IW + 1)'(N);
            end
            if (req_vld[scan[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[IW-1:0];
            end
        end
    end

    assign grant   = (state == S_IDLE) && en && win_found;
    assign req_rdy = grant ? ({{(N-1){1'b0}}, 1'b1} << win_idx) : '0;
    assign num_eff = (num == '0) ? CW'(1) : num;
    assign busy    = (state == S_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cdc_st   <= 1'b0;
            cdc_data <= '0;
            cdc_id   <= '0;
            ptr      <= '0;
            cnt      <= '0;
            num_q    <= CW'(1);
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        cdc_data <= req_data[win_idx*DW +: DW];
                        cdc_id   <= win_idx;
                        cdc_st   <= ~cdc_st;
                        num_q    <= num_eff;
                        cnt      <= '0;
                        ptr      <= (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
                        state    <= S_HOLD;
                    end
                end
                default: begin
                    // Hold length is fixed by num_q captured at grant.
                    if (cnt == num_q - CW'(1)) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule
